// File: rtl/mmio_bus_router_pkg.sv
// Shared types and constants for the MMIO bus router and its decoder.
package mmio_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } mmioStateT;

  localparam logic [31:0] DEFAULT_BASE_ADDR = 32'hFFFF_FC00;

  // Fixed channel slots of the standard board map
  localparam int unsigned CH_LED    = 0;
  localparam int unsigned CH_SWITCH = 1;
  localparam int unsigned CH_TUBE   = 2;
  localparam int unsigned CH_UART   = 3;

  // Index width for n items, never below one bit
  function automatic int unsigned idxWidth(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mmio_bus_router_if.sv
// CPU-side request/response and channel-side strobe bundle of the router.
interface mmio_bus_router_if #(
  parameter int unsigned N_CH      = 4,
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned CH_ADDR_W = 4
);
  logic                   iReq;
  logic                   iWrite;
  logic [ADDR_W-1:0]      iAddr;
  logic [DATA_W-1:0]      iWData;
  logic [DATA_W-1:0]      oRData;
  logic                   oReady;
  logic                   oError;
  logic                   oBusy;
  logic [7:0]             oErrCount;
  logic [N_CH-1:0]        oChSel;
  logic                   oChWrite;
  logic [CH_ADDR_W-1:0]   oChAddr;
  logic [DATA_W-1:0]      oChWData;
  logic [N_CH-1:0]        iChReady;
  logic [N_CH*DATA_W-1:0] iChRData;

  // Router side
  modport slave (
    input  iReq, iWrite, iAddr, iWData, iChReady, iChRData,
    output oRData, oReady, oError, oBusy, oErrCount,
           oChSel, oChWrite, oChAddr, oChWData
  );

  // CPU plus peripheral side
  modport master (
    output iReq, iWrite, iAddr, iWData, iChReady, iChRData,
    input  oRData, oReady, oError, oBusy, oErrCount,
           oChSel, oChWrite, oChAddr, oChWData
  );
endinterface

// File: rtl/mmio_addr_decode.sv
// Combinational IO-window decode: region hit, channel index and byte offset.
module mmio_addr_decode
  import mmio_pkg::*;
#(
  parameter int unsigned       N_CH      = 4,
  parameter int unsigned       ADDR_W    = 32,
  parameter int unsigned       CH_ADDR_W = 4,
  parameter logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(DEFAULT_BASE_ADDR),
  parameter int unsigned       IDX_W     = idxWidth(N_CH)
) (
  input  logic [ADDR_W-1:0]    iAddr,
  output logic                 oHit_c,
  output logic [IDX_W-1:0]     oIdx_c,
  output logic [CH_ADDR_W-1:0] oOffset_c
);
  localparam int unsigned TAG_LSB = CH_ADDR_W + IDX_W;
  localparam int unsigned IDXC_W  = IDX_W + 1;

  // Region tag must match and the index must name an existing channel
  always_comb begin
    oIdx_c    = iAddr[CH_ADDR_W +: IDX_W];
    oOffset_c = iAddr[CH_ADDR_W-1:0];
    oHit_c    = (iAddr[ADDR_W-1:TAG_LSB] == BASE_ADDR[ADDR_W-1:TAG_LSB]) &&
                ({1'b0, oIdx_c} < IDXC_W'(N_CH));
  end

endmodule

// File: rtl/mmio_bus_router.sv
// Address-decoded MMIO router: one CPU data port fanned out to N_CH channels
// with per-access ready handshake, timeout and saturating error count.
module mmio_bus_router
  import mmio_pkg::*;
#(
  parameter int unsigned       N_CH      = 4,
  parameter int unsigned       ADDR_W    = 32,
  parameter int unsigned       DATA_W    = 32,
  parameter int unsigned       CH_ADDR_W = 4,
  parameter logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(DEFAULT_BASE_ADDR),
  parameter int unsigned       TIMEOUT   = 8
) (
  input logic               iCpuClock,
  input logic               iCpuReset,
  mmio_bus_router_if.slave  bus
);
  localparam int unsigned IDX_W = idxWidth(N_CH);
  localparam int unsigned CNT_W = idxWidth(TIMEOUT);

  mmioStateT            state, stateNext;
  logic [IDX_W-1:0]     idxQ, idxNext;
  logic [CNT_W-1:0]     waitCnt, waitCntNext;
  logic [DATA_W-1:0]    rDataQ, rDataNext;
  logic                 readyQ, readyNext;
  logic                 errorQ, errorNext;
  logic                 busyQ, busyNext;
  logic [7:0]           errCountQ, errCountNext;
  logic [N_CH-1:0]      chSelQ, chSelNext;
  logic                 chWriteQ, chWriteNext;
  logic [CH_ADDR_W-1:0] chAddrQ, chAddrNext;
  logic [DATA_W-1:0]    chWDataQ, chWDataNext;

  logic                 decHit_c;
  logic [IDX_W-1:0]     decIdx_c;
  logic [CH_ADDR_W-1:0] decOffset_c;
  logic                 selReady_c;
  logic [DATA_W-1:0]    selData_c;

  mmio_addr_decode #(
    .N_CH      (N_CH),
    .ADDR_W    (ADDR_W),
    .CH_ADDR_W (CH_ADDR_W),
    .BASE_ADDR (BASE_ADDR),
    .IDX_W     (IDX_W)
  ) u_decode (
    .iAddr     (bus.iAddr),
    .oHit_c    (decHit_c),
    .oIdx_c    (decIdx_c),
    .oOffset_c (decOffset_c)
  );

  // Ready and read data of the latched channel; other channels are ignored
  always_comb begin
    selReady_c = 1'b0;
    selData_c  = '0;
    for (int k = 0; k < int'(N_CH); k++) begin
      if (idxQ == IDX_W'(k)) begin
        selReady_c = bus.iChReady[k];
        selData_c  = bus.iChRData[k*DATA_W +: DATA_W];
      end
    end
  end

  // Next state and next values of every registered output
  always_comb begin
    stateNext    = state;
    idxNext      = idxQ;
    waitCntNext  = waitCnt;
    rDataNext    = '0;
    errorNext    = 1'b0;
    errCountNext = errCountQ;
    chWriteNext  = chWriteQ;
    chAddrNext   = chAddrQ;
    chWDataNext  = chWDataQ;

    case (state)
      IDLE: begin
        if (bus.iReq) begin
          if (decHit_c) begin
            stateNext   = ACCESS;
            idxNext     = decIdx_c;
            waitCntNext = '0;
            chWriteNext = bus.iWrite;
            chAddrNext  = decOffset_c;
            chWDataNext = bus.iWData;
          end else begin
            stateNext = RESP;
            errorNext = 1'b1;
          end
        end
      end
      ACCESS: begin
        if (selReady_c) begin
          stateNext = RESP;
          rDataNext = chWriteQ ? '0 : selData_c;
        end else if (waitCnt == CNT_W'(TIMEOUT - 1)) begin
          stateNext = RESP;
          errorNext = 1'b1;
        end else begin
          waitCntNext = waitCnt + 1'b1;
        end
      end
      RESP:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase

    readyNext = (stateNext == RESP);
    busyNext  = (stateNext != IDLE);
    chSelNext = (stateNext == ACCESS) ? (N_CH'(1) << idxNext) : '0;
    if (readyNext && errorNext && (errCountQ != 8'hFF)) begin
      errCountNext = errCountQ + 8'd1;
    end
  end

  // State and output registers; reset aborts any transfer in flight
  always_ff @(posedge iCpuClock or negedge iCpuReset) begin
    if (!iCpuReset) begin
      state     <= IDLE;
      idxQ      <= '0;
      waitCnt   <= '0;
      rDataQ    <= '0;
      readyQ    <= 1'b0;
      errorQ    <= 1'b0;
      busyQ     <= 1'b0;
      errCountQ <= '0;
      chSelQ    <= '0;
      chWriteQ  <= 1'b0;
      chAddrQ   <= '0;
      chWDataQ  <= '0;
    end else begin
      state     <= stateNext;
      idxQ      <= idxNext;
      waitCnt   <= waitCntNext;
      rDataQ    <= rDataNext;
      readyQ    <= readyNext;
      errorQ    <= errorNext;
      busyQ     <= busyNext;
      errCountQ <= errCountNext;
      chSelQ    <= chSelNext;
      chWriteQ  <= chWriteNext;
      chAddrQ   <= chAddrNext;
      chWDataQ  <= chWDataNext;
    end
  end

  assign bus.oRData    = rDataQ;
  assign bus.oReady    = readyQ;
  assign bus.oError    = errorQ;
  assign bus.oBusy     = busyQ;
  assign bus.oErrCount = errCountQ;
  assign bus.oChSel    = chSelQ;
  assign bus.oChWrite  = chWriteQ;
  assign bus.oChAddr   = chAddrQ;
  assign bus.oChWData  = chWDataQ;

endmodule
